uart_rx_fifo: RTL and testbench

Byte FIFO placed between `uart_rx` and `ram_rw`, decoupling serial reception from the loader's command/RAM-write processing. It accepts bytes from `uart_rx` over a valid/ready handshake, buffers up to `DEPTH` bytes, and presents them first-word-fall-through to `ram_rw`. It also provides fill level, almost-full and sticky-overflow status, plus a synchronous flush.

---
 rtl/uart_rx_fifo.sv | 73 +++++++
 tb/tb_uart_rx_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between uart_rx and ram_rw: valid/ready on both sides, first-word-fall-through
// output, fill level, almost-full and sticky overflow status, synchronous flush.
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [7:0]               in_data_i,
  input  logic                     in_vld_i,
  output logic                     in_rdy_o,
  output logic [7:0]               out_data_o,
  output logic                     out_vld_o,
  input  logic                     out_rdy_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     afull_o,
  output logic                     ovf_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Handshake readiness depends on the count register only, never on the partner's strobe.
  assign w_full    = (r_count == DEPTH_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push    = in_vld_i & ~w_full;
  assign w_pop     = out_rdy_i & ~w_empty;

  assign in_rdy_o   = ~w_full;
  assign out_vld_o  = ~w_empty;
  assign out_data_o = r_mem[r_rd_ptr];
  assign level_o    = r_count;
  assign afull_o    = (r_count >= AF_CNT);
  assign ovf_o      = r_ovf;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (in_vld_i && w_full) r_ovf <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; a push discarded by reset or flush leaves it untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && w_push) r_mem[r_wr_ptr] <= in_data_i;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a queue-based model of the FIFO behaviour.
module tb_uart_rx_fifo;

  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = 12;

  logic       clk = 1'b0;
  logic       rst_i, flush_i, in_vld_i, out_rdy_i;
  logic [7:0] in_data_i;
  logic       in_rdy_o, out_vld_o, afull_o, ovf_o;
  logic [7:0] out_data_o;
  logic [$clog2(DEPTH):0] level_o;

  uart_rx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_data_i(in_data_i), .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o),
    .out_data_o(out_data_o), .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
    .level_o(level_o), .afull_o(afull_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;

  typedef struct {
    logic       rst, flush, vld;
    logic [7:0] data;
    logic       rdy;
    int         lvl;
    logic       ovld;
    logic [7:0] odata;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare all outputs just after the edge.
  task automatic cycle(input logic r, input logic f, input logic v, input logic [7:0] d,
                       input logic rd);
    int n;
    rst_i = r; flush_i = f; in_vld_i = v; in_data_i = d; out_rdy_i = rd;
    @(posedge clk);
    #1;
    if (r || f) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      n = mq.size();
      if (v && n == DEPTH) m_ovf = 1'b1;
      if (rd && n > 0) void'(mq.pop_front());
      if (v && n < DEPTH) mq.push_back(d);
    end
    chk("level", 32'(level_o), 32'(mq.size()));
    chk("in_rdy", 32'(in_rdy_o), 32'(mq.size() != DEPTH));
    chk("out_vld", 32'(out_vld_o), 32'(mq.size() != 0));
    chk("afull", 32'(afull_o), 32'(mq.size() >= AF_LEVEL));
    chk("ovf", 32'(ovf_o), 32'(m_ovf));
    if (mq.size() != 0) chk("out_data", 32'(out_data_o), 32'(mq[0]));
  endtask

  logic [7:0] seq[16];

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; in_vld_i = 1'b0; in_data_i = 8'h00; out_rdy_i = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h2a, 1'b0, 1, 1'b1, 8'h2a};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h2c, 1'b0, 2, 1'b1, 8'h2a};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h2c};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1, 1'b1, 8'h33};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 0, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1, 1'b1, 8'h55};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].rst, tbl[i].flush, tbl[i].vld, tbl[i].data, tbl[i].rdy);
      chk($sformatf("vec%0d_level", i), 32'(level_o), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d_out_vld", i), 32'(out_vld_o), 32'(tbl[i].ovld));
      if (tbl[i].ovld) chk($sformatf("vec%0d_out_data", i), 32'(out_data_o), 32'(tbl[i].odata));
    end

    // Fill to full with the consumer stalled.
    seq[0] = 8'h2a; seq[1] = 8'h2c;
    for (int i = 2; i < 16; i++) seq[i] = 8'(i - 2);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 1'b1, seq[i], 1'b0);
      if (i == 10) chk("afull_at_11", 32'(afull_o), 32'd0);
      if (i == 11) chk("afull_at_12", 32'(afull_o), 32'd1);
    end
    chk("full_level", 32'(level_o), 32'd16);
    chk("full_in_rdy", 32'(in_rdy_o), 32'd0);

    // Overflow attempt: byte must be dropped, flag must stick.
    cycle(1'b0, 1'b0, 1'b1, 8'haa, 1'b0);
    chk("ovf_set", 32'(ovf_o), 32'd1);
    chk("ovf_level", 32'(level_o), 32'd16);

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), 32'(out_data_o), 32'(seq[i]));
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      if (i == 0) chk("freed_in_rdy", 32'(in_rdy_o), 32'd1);
      chk("ovf_sticky", 32'(ovf_o), 32'd1);
    end
    chk("drained_out_vld", 32'(out_vld_o), 32'd0);

    // Sustained push+pop at level 5 across several pointer wraps.
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b1, 8'(k), 1'b0);
    for (int k = 5; k < 45; k++) begin
      chk($sformatf("conc_head%0d", k), 32'(out_data_o), 32'(k - 5));
      cycle(1'b0, 1'b0, 1'b1, 8'(k), 1'b1);
      chk("conc_level", 32'(level_o), 32'd5);
    end

    // Flush at level 7 with a concurrent push and pop.
    cycle(1'b0, 1'b0, 1'b1, 8'h70, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h71, 1'b0);
    chk("pre_flush_level", 32'(level_o), 32'd7);
    cycle(1'b0, 1'b1, 1'b1, 8'h99, 1'b1);
    chk("flush_level", 32'(level_o), 32'd0);
    chk("flush_out_vld", 32'(out_vld_o), 32'd0);
    chk("flush_ovf", 32'(ovf_o), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
    chk("post_flush_head", 32'(out_data_o), 32'h55);

    // Loader stream through the FIFO with a stalling consumer; no overflow expected.
    begin
      logic [7:0] stream[$];
      logic [7:0] got[$];
      int guard;
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      stream = '{8'h2a, 8'h2c, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0f, 8'h00, 8'h00, 8'h00, 8'h2e};
      for (int i = 0; i < 16; i++) stream.push_back(8'($urandom));
      stream.push_back(8'h2b);
      guard = 0;
      for (int i = 0; i < stream.size() && guard < 2000; guard++) begin
        logic rd;
        logic v;
        v  = ($urandom_range(0, 3) != 0) && in_rdy_o;
        rd = ($urandom_range(0, 2) == 0);
        if (rd && out_vld_o) got.push_back(out_data_o);
        cycle(1'b0, 1'b0, v, stream[i], rd);
        if (v) i++;
      end
      for (int g = 0; g < 200 && out_vld_o; g++) begin
        got.push_back(out_data_o);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      end
      chk("sys_count", 32'(got.size()), 32'(stream.size()));
      for (int i = 0; i < got.size() && i < stream.size(); i++)
        if (got[i] !== stream[i]) chk($sformatf("sys_byte%0d", i), 32'(got[i]), 32'(stream[i]));
      chk("sys_ovf", 32'(ovf_o), 32'd0);
    end

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      cycle(($urandom_range(0, 255) == 0), ($urandom_range(0, 63) == 0),
            ($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
